// File: rtl/tank_ctrl_pkg.sv
// Shared state encoding, default timing and dry-run debounce depth for the
// tank pump arbiter.
package tank_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPEN  = 3'd1,
        PUMP  = 3'd2,
        CLOSE = 3'd3,
        COOL  = 3'd4
    } state_t;

    localparam int DEF_VALVE_SETTLE = 8;
    localparam int DEF_MIN_RUN      = 16;
    localparam int DEF_MAX_RUN      = 1024;
    localparam int DEF_MIN_OFF      = 32;

    // Consecutive sump_low samples in PUMP that count as running dry.
    localparam int DRY_DEBOUNCE     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after
// last_grant, wrapping modulo N_TANKS.
module rr_arbiter #(
    parameter int N_TANKS = 4,
    localparam int IW = $clog2(N_TANKS)
) (
    input  logic [N_TANKS-1:0] eligible,
    input  logic [IW-1:0]      last_grant,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Offsets 1..N visit every index once, last_grant itself last.
        for (int k = 1; k <= N_TANKS; k++) begin
            for (int i = 0; i < N_TANKS; i++) begin
                if (!valid && eligible[i] && ((int'(last_grant) + k) % N_TANKS == i)) begin
                    valid = 1'b1;
                    idx   = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/tank_pump_arbiter.sv
// Shares one supply pump among N_TANKS tanks: round-robin grant, valve settle,
// pump run with min/max limits, valve close and cool-down. PUMP_DRY_RUN_EN adds sump dry-run protection.
module tank_pump_arbiter
    import tank_ctrl_pkg::*;
#(
    parameter int N_TANKS      = 4,
    parameter int VALVE_SETTLE = DEF_VALVE_SETTLE,
    parameter int MIN_RUN      = DEF_MIN_RUN,
    parameter int MAX_RUN      = DEF_MAX_RUN,
    parameter int MIN_OFF      = DEF_MIN_OFF,
    localparam int IW = $clog2(N_TANKS),
    localparam int CW = $clog2(MAX_RUN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_TANKS-1:0] fill_req,
    input  logic [N_TANKS-1:0] full_flag,
    input  logic               fault_clr,
    output logic [N_TANKS-1:0] valve_open,
    output logic               pump_on,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    output logic [N_TANKS-1:0] timeout_fault
`ifdef PUMP_DRY_RUN_EN
    ,
    input  logic               sump_low,
    output logic               dry_fault
`endif
);

    localparam logic [CW-1:0] SETTLE_TC  = CW'(VALVE_SETTLE - 1);
    localparam logic [CW-1:0] MIN_RUN_TC = CW'(MIN_RUN - 1);
    localparam logic [CW-1:0] MAX_RUN_TC = CW'(MAX_RUN - 1);
    localparam logic [CW-1:0] MIN_OFF_TC = CW'(MIN_OFF - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [IW-1:0]      last_grant, grant_nxt, arb_idx;
    logic [N_TANKS-1:0] gmask, eligible, fault_set;
    logic               req_g, full_g, arb_valid, grant_ok, dry_trip;

    assign gmask    = N_TANKS'(1) << grant_id;
    assign req_g    = |(fill_req & gmask);
    assign full_g   = |(full_flag & gmask);
    assign eligible = fill_req & ~full_flag & ~timeout_fault;

    rr_arbiter #(.N_TANKS(N_TANKS)) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .idx        (arb_idx)
    );

`ifdef PUMP_DRY_RUN_EN
    localparam int DW = $clog2(DRY_DEBOUNCE + 1);
    logic [DW-1:0] dry_cnt;

    assign dry_trip = (state == PUMP) && sump_low && (dry_cnt == DW'(DRY_DEBOUNCE - 1));
    assign grant_ok = ~dry_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            dry_cnt   <= '0;
            dry_fault <= 1'b0;
        end else begin
            dry_cnt <= (state == PUMP && sump_low) ? dry_cnt + 1'b1 : '0;
            if (dry_trip)
                dry_fault <= 1'b1;
            else if (fault_clr)
                dry_fault <= 1'b0;
        end
    end
`else
    assign dry_trip = 1'b0;
    assign grant_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        grant_nxt = grant_id;
        fault_set = '0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (arb_valid && grant_ok) begin
                    state_nxt = OPEN;
                    grant_nxt = arb_idx;
                end
            end
            OPEN: begin
                if (!req_g || full_g)
                    state_nxt = CLOSE;
                else if (cnt == SETTLE_TC)
                    state_nxt = PUMP;
            end
            PUMP: begin
                // Overflow and dry-run stops bypass the minimum run time.
                if (full_g || dry_trip) begin
                    state_nxt = CLOSE;
                end else if (cnt == MAX_RUN_TC) begin
                    state_nxt = CLOSE;
                    fault_set = gmask;
                end else if (!req_g && cnt >= MIN_RUN_TC) begin
                    state_nxt = CLOSE;
                end
            end
            CLOSE: if (cnt == SETTLE_TC) state_nxt = COOL;
            COOL:  if (cnt == MIN_OFF_TC) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= IW'(N_TANKS - 1);
            grant_id      <= '0;
            busy          <= 1'b0;
            pump_on       <= 1'b0;
            valve_open    <= '0;
            timeout_fault <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            grant_id <= grant_nxt;
            busy     <= (state_nxt != IDLE);
            pump_on  <= (state_nxt == PUMP);
            valve_open <= (state_nxt inside {OPEN, PUMP, CLOSE}) ? (N_TANKS'(1) << grant_nxt) : '0;
            if (state == IDLE && state_nxt == OPEN)
                last_grant <= arb_idx;
            timeout_fault <= (fault_clr ? '0 : timeout_fault) | fault_set;
        end
    end

endmodule

// File: tb/tb_tank_pump_arbiter.sv
// Self-checking bench for tank_pump_arbiter: directed vector table plus
// hand-written multi-cycle sequences (dry-run sequence when PUMP_DRY_RUN_EN).
module tb_tank_pump_arbiter;

    logic       clk = 1'b0;
    logic       reset, fault_clr;
    logic [3:0] fill_req, full_flag, valve_open, timeout_fault;
    logic       pump_on, busy;
    logic [1:0] grant_id;
`ifdef PUMP_DRY_RUN_EN
    logic       sump_low, dry_fault;
`endif

    int tests   = 0;
    int fails   = 0;
    int inv_err = 0;

    always #5 clk = ~clk;

    tank_pump_arbiter #(
        .N_TANKS(4), .VALVE_SETTLE(8), .MIN_RUN(16), .MAX_RUN(64), .MIN_OFF(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fill_req      (fill_req),
        .full_flag     (full_flag),
        .fault_clr     (fault_clr),
        .valve_open    (valve_open),
        .pump_on       (pump_on),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_fault (timeout_fault)
`ifdef PUMP_DRY_RUN_EN
        ,
        .sump_low      (sump_low),
        .dry_fault     (dry_fault)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] full;
        logic       clr;
        int         n;
        logic [3:0] valve;
        logic       pump;
        logic       bsy;
        logic       chk_gid;
        logic [1:0] gid;
        logic [3:0] tf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [3:0] req, logic [3:0] full, logic clr, int n,
                                logic [3:0] valve, logic pump, logic bsy, logic chk_gid,
                                logic [1:0] gid, logic [3:0] tf);
        vec_t v;
        v.rst = rst; v.req = req; v.full = full; v.clr = clr; v.n = n;
        v.valve = valve; v.pump = pump; v.bsy = bsy; v.chk_gid = chk_gid; v.gid = gid; v.tf = tf;
        vecs.push_back(v);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] v, input logic p, input logic b,
                         input logic cg, input logic [1:0] g, input logic [3:0] tf);
        tests++;
        if (valve_open !== v || pump_on !== p || busy !== b || timeout_fault !== tf ||
            (cg && grant_id !== g)) begin
            fails++;
            $display("FAIL %s: got valve=%b pump=%b busy=%b gid=%0d tf=%b, want valve=%b pump=%b busy=%b gid=%0d(chk=%b) tf=%b",
                     name, valve_open, pump_on, busy, grant_id, timeout_fault, v, p, b, g, cg, tf);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b after %0d cycles, want 0", name, busy, budget);
        end
    endtask

    // Structural invariants: one valve at most, pump only with its valve open.
    always @(negedge clk)
        if (!$onehot0(valve_open) || (pump_on && !valve_open[grant_id]))
            inv_err++;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 time units");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] m;
        logic       pump_seen;

        reset = 1'b1; fill_req = '0; full_flag = '0; fault_clr = 1'b0;
`ifdef PUMP_DRY_RUN_EN
        sump_low = 1'b0;
`endif

        // Single request, drop after a long run, close and cool-down.
        add(1, 4'b0000, 0, 0,  2, 4'b0000, 0, 0, 1, 0, 0);
        add(0, 4'b0010, 0, 0,  1, 4'b0010, 0, 1, 1, 1, 0);
        add(0, 4'b0010, 0, 0,  7, 4'b0010, 0, 1, 1, 1, 0);
        add(0, 4'b0010, 0, 0,  1, 4'b0010, 1, 1, 1, 1, 0);
        add(0, 4'b0010, 0, 0, 39, 4'b0010, 1, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 0,  1, 4'b0010, 0, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 0,  7, 4'b0010, 0, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 0,  1, 4'b0000, 0, 1, 1, 1, 0);
        add(0, 4'b0000, 0, 0, 31, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 4'b0000, 0, 0,  1, 4'b0000, 0, 0, 0, 0, 0);

        // All four requesting, each grant ended by full: order 0,1,2,3,0.
        add(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0);
        for (int t = 0; t < 4; t++) begin
            m = 4'b0001 << t;
            add(0, 4'hF, 0, 0,  1, m,       0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0,  7, m,       0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0,  1, m,       1, 1, 1, 2'(t), 0);
            add(0, 4'hF, m, 0,  1, m,       0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0,  7, m,       0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0,  1, 4'b0000, 0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0, 31, 4'b0000, 0, 1, 1, 2'(t), 0);
            add(0, 4'hF, 0, 0,  1, 4'b0000, 0, 0, 0, 0, 0);
        end
        add(0, 4'hF, 0, 0, 1, 4'b0001, 0, 1, 1, 0, 0);

        // Early drop honoured at MIN_RUN; full stops the pump at once.
        add(0, 4'hF,    0, 0,  7, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 4'hF,    0, 0,  1, 4'b0001, 1, 1, 1, 0, 0);
        add(0, 4'hF,    0, 0,  4, 4'b0001, 1, 1, 1, 0, 0);
        add(0, 4'b1110, 0, 0, 11, 4'b0001, 1, 1, 1, 0, 0);
        add(0, 4'b1110, 0, 0,  1, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 4'b0001, 0, 0,  8, 4'b0000, 0, 1, 1, 0, 0);
        add(0, 4'b0001, 0, 0, 32, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 4'b0001, 0, 0,  8, 4'b0001, 1, 1, 1, 0, 0);
        add(0, 4'b0001, 0, 0,  5, 4'b0001, 1, 1, 1, 0, 0);
        add(0, 4'b0001, 4'b0001, 0, 1, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 0,  8, 4'b0000, 0, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 32, 4'b0000, 0, 0, 0, 0, 0);

        // Timeout fault, exclusion, clear and regrant.
        add(0, 4'b0100, 0, 0,  1, 4'b0100, 0, 1, 1, 2, 4'b0000);
        add(0, 4'b0100, 0, 0,  8, 4'b0100, 1, 1, 1, 2, 4'b0000);
        add(0, 4'b0100, 0, 0, 63, 4'b0100, 1, 1, 1, 2, 4'b0000);
        add(0, 4'b0100, 0, 0,  1, 4'b0100, 0, 1, 1, 2, 4'b0100);
        add(0, 4'b0100, 0, 0,  8, 4'b0000, 0, 1, 1, 2, 4'b0100);
        add(0, 4'b0100, 0, 0, 32, 4'b0000, 0, 0, 0, 0, 4'b0100);
        add(0, 4'b0100, 0, 0,  5, 4'b0000, 0, 0, 0, 0, 4'b0100);
        add(0, 4'b0100, 0, 1,  1, 4'b0000, 0, 0, 0, 0, 4'b0000);
        add(0, 4'b0100, 0, 0,  1, 4'b0100, 0, 1, 1, 2, 4'b0000);

        // Reset mid-PUMP drops everything; priority restarts at tank 0.
        add(0, 4'b0100, 0, 0,  8, 4'b0100, 1, 1, 1, 2, 0);
        add(0, 4'b0100, 0, 0,  3, 4'b0100, 1, 1, 1, 2, 0);
        add(1, 4'b0100, 0, 0,  1, 4'b0000, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0,  1, 4'b0001, 0, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            fill_req  = vecs[i].req;
            full_flag = vecs[i].full;
            fault_clr = vecs[i].clr;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].valve, vecs[i].pump, vecs[i].bsy,
                  vecs[i].chk_gid, vecs[i].gid, vecs[i].tf);
        end

        // Timeout set coinciding with fault_clr: the set wins.
        reset = 1'b1; fill_req = '0; full_flag = '0; fault_clr = 1'b0;
        step(1);
        reset = 1'b0; fill_req = 4'b1000;
        step(1);
        check("sw_grant", 4'b1000, 0, 1, 1, 3, 4'b0000);
        step(8);
        check("sw_pump", 4'b1000, 1, 1, 1, 3, 4'b0000);
        step(63);
        fault_clr = 1'b1;
        step(1);
        check("sw_set_wins", 4'b1000, 0, 1, 1, 3, 4'b1000);
        fault_clr = 1'b0;
        step(1);
        check("sw_sticky", 4'b1000, 0, 1, 1, 3, 4'b1000);
        wait_idle("sw_idle", 60);
        step(3);
        check("sw_excluded", 4'b0000, 0, 0, 0, 0, 4'b1000);

        // Request dropped during OPEN: pump never starts, valve closes after settle.
        fill_req = 4'b0010;
        step(1);
        check("ab_grant", 4'b0010, 0, 1, 1, 1, 4'b1000);
        step(3);
        fill_req = 4'b0000;
        step(1);
        check("ab_close", 4'b0010, 0, 1, 1, 1, 4'b1000);
        pump_seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            pump_seen |= pump_on;
        end
        tests++;
        if (pump_seen !== 1'b0) begin
            fails++;
            $display("FAIL ab_no_pump: pump_on seen=%b during close, want 0", pump_seen);
        end
        step(1);
        check("ab_valve_off", 4'b0000, 0, 1, 1, 1, 4'b1000);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("ab_clr", 4'b0000, 0, 1, 1, 1, 4'b0000);
        wait_idle("ab_idle", 40);

`ifdef PUMP_DRY_RUN_EN
        reset = 1'b1;
        step(1);
        reset = 1'b0; fill_req = 4'b0001;
        step(9);
        check("dry_pump", 4'b0001, 1, 1, 1, 0, 0);
        sump_low = 1'b1;
        step(3);
        sump_low = 1'b0;
        step(1);
        check("dry_short", 4'b0001, 1, 1, 1, 0, 0);
        sump_low = 1'b1;
        step(3);
        check("dry_three", 4'b0001, 1, 1, 1, 0, 0);
        step(1);
        check("dry_trip", 4'b0001, 0, 1, 1, 0, 0);
        tests++;
        if (dry_fault !== 1'b1) begin
            fails++;
            $display("FAIL dry_fault_set: got %b want 1", dry_fault);
        end
        sump_low = 1'b0;
        wait_idle("dry_idle", 60);
        step(3);
        check("dry_blocked", 4'b0000, 0, 0, 0, 0, 0);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        tests++;
        if (dry_fault !== 1'b0) begin
            fails++;
            $display("FAIL dry_fault_clr: got %b want 0", dry_fault);
        end
        step(1);
        check("dry_regrant", 4'b0001, 0, 1, 1, 0, 0);
`endif

        tests++;
        if (inv_err != 0) begin
            fails++;
            $display("FAIL invariants: got %0d violating cycles, want 0", inv_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
